// File: rtl/paddle_ctrl.sv
// paddle_ctrl: button-driven clamped paddle position with erase/redraw pixel plotter.
module paddle_ctrl #(
    parameter int X_BITS = 8,
    parameter int Y_BITS = 7,
    parameter int COLOUR_BITS = 3,
    parameter int SCREEN_W = 160,
    parameter int PADDLE_W = 16,
    parameter int PADDLE_H = 2,
    parameter int PADDLE_Y = 112,
    parameter int X_INIT = 72,
    parameter int STEP = 4,
    parameter logic [COLOUR_BITS-1:0] PADDLE_COLOUR = 3'b111,
    parameter logic [COLOUR_BITS-1:0] BG_COLOUR = 3'b000
) (
    input  logic                   CLOCK_50,
    input  logic                   resetn,
    input  logic                   left_n,
    input  logic                   right_n,
    output logic [X_BITS-1:0]      x,
    output logic [Y_BITS-1:0]      y,
    output logic [COLOUR_BITS-1:0] colour,
    output logic                   plot,
    output logic                   busy,
    output logic [X_BITS-1:0]      paddle_x
);
    typedef enum logic [1:0] {START, IDLE, ERASE, DRAW} state_t;
    localparam logic [X_BITS:0]   MAX_X  = (X_BITS+1)'(SCREEN_W - PADDLE_W);
    localparam logic [X_BITS:0]   STEP_W = (X_BITS+1)'(STEP);
    localparam logic [X_BITS-1:0] LAST_I = X_BITS'(PADDLE_W - 1);
    localparam logic [Y_BITS-1:0] LAST_J = Y_BITS'(PADDLE_H - 1);
    state_t r_state, w_next;
    logic r_s1_l, r_s2_l, r_pv_l, r_s1_r, r_s2_r, r_pv_r;
    logic [1:0] r_pend, w_press, w_req;
    logic [X_BITS-1:0] r_px, r_old, r_i, r_x, w_ox;
    logic [Y_BITS-1:0] r_j, r_y, w_oy;
    logic [COLOUR_BITS-1:0] r_col, w_col;
    logic [X_BITS:0] w_px, w_sum, w_tgt;
    logic r_plot, r_busy, w_l, w_r, w_i_end, w_last, w_dec, w_move, w_busy;
    // a press is the first synchronised low sample; simultaneous presses cancel
    assign w_l     = ~r_s2_l & r_pv_l;
    assign w_r     = ~r_s2_r & r_pv_r;
    assign w_press = (w_l ^ w_r) ? {w_r, w_l} : 2'b00;
    assign w_req   = (w_press != 2'b00) ? w_press : r_pend;
    assign w_i_end = r_i == LAST_I;
    assign w_last  = w_i_end && r_j == LAST_J;
    assign w_dec   = r_state == IDLE || (r_state == DRAW && w_last);
    assign w_px    = {1'b0, r_px};
    assign w_sum   = w_px + STEP_W;
    assign w_tgt   = w_req[0] ? ((w_px >= STEP_W) ? w_px - STEP_W : '0) :
                     w_req[1] ? ((w_sum > MAX_X) ? MAX_X : w_sum) : w_px;
    assign w_move  = w_dec && w_req != 2'b00 && w_tgt != w_px;
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) r_state <= START;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == START) ? DRAW :
                 w_move ? ERASE :
                 (r_state == IDLE) ? IDLE :
                 !w_last ? r_state :
                 (r_state == ERASE) ? DRAW : IDLE;
    end
    always_comb begin
        w_busy = r_state == ERASE || r_state == DRAW;
        w_ox   = ((r_state == ERASE) ? r_old : r_px) + r_i;
        w_oy   = Y_BITS'(PADDLE_Y) + r_j;
        w_col  = (r_state == ERASE) ? BG_COLOUR : PADDLE_COLOUR;
    end
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            {r_s1_l, r_s2_l, r_pv_l, r_s1_r, r_s2_r, r_pv_r} <= '1;
            r_pend <= 2'b00;
            r_px   <= X_BITS'(X_INIT);
            r_old  <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_col  <= '0;
            r_plot <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            {r_s1_l, r_s2_l, r_pv_l} <= {left_n, r_s1_l, r_s2_l};
            {r_s1_r, r_s2_r, r_pv_r} <= {right_n, r_s1_r, r_s2_r};
            r_pend <= w_dec ? 2'b00 : w_req;
            if (w_move) begin
                r_old <= r_px;
                r_px  <= w_tgt[X_BITS-1:0];
            end
            if (w_busy) begin
                r_i <= w_i_end ? '0 : r_i + 1'b1;
                r_j <= !w_i_end ? r_j : w_last ? '0 : r_j + 1'b1;
            end
            r_x    <= w_ox;
            r_y    <= w_oy;
            r_col  <= w_col;
            r_plot <= w_busy;
            r_busy <= w_busy;
        end
    end
    assign x        = r_x;
    assign y        = r_y;
    assign colour   = r_col;
    assign plot     = r_plot;
    assign busy     = r_busy;
    assign paddle_x = r_px;
endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: directed checks of paddle moves, clamping, pending requests and redraw scans.
module tb_paddle_ctrl;
    logic clk = 1'b0, resetn = 1'b0, left_n = 1'b1, right_n = 1'b1, left2_n = 1'b1;
    logic [7:0] x, paddle_x, x2, px2;
    logic [6:0] y, y2;
    logic [2:0] colour, col2;
    logic plot, busy, plot2, busy2;
    int n_chk = 0, n_fail = 0;
    int busy_cnt = 0, run = 0, max_run = 0;
    logic [17:0] q[$];

    paddle_ctrl dut (.CLOCK_50(clk), .resetn(resetn), .left_n(left_n), .right_n(right_n),
                     .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .paddle_x(paddle_x));
    paddle_ctrl #(.X_INIT(2)) dut2 (.CLOCK_50(clk), .resetn(resetn), .left_n(left2_n), .right_n(1'b1),
                     .x(x2), .y(y2), .colour(col2), .plot(plot2), .busy(busy2), .paddle_x(px2));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (plot) q.push_back({x, y, colour});
        if (busy) begin
            busy_cnt++;
            run++;
            if (run > max_run) max_run = run;
        end else run = 0;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        q.delete();
        busy_cnt = 0;
        max_run = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input string tag, input int off, input int x0, input int col);
        int bad = 0;
        logic [17:0] e;
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < 16; i++) begin
                e = {8'(x0 + i), 7'(112 + j), 3'(col)};
                if (off + j * 16 + i >= q.size() || q[off + j * 16 + i] != e) bad++;
            end
        chk(tag, bad, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(2);
        clr();
        resetn = 1'b1;
        cyc(40);
    endtask

    task automatic press_r();
        right_n = 1'b0;
        cyc(3);
        right_n = 1'b1;
        cyc(75);
    endtask

    initial begin
        int lat;
        cyc(2);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddle_x", paddle_x, 72);
        clr();
        resetn = 1'b1;
        cyc(40);
        chk("init_pixels", q.size(), 32);
        scan("init_draw", 0, 72, 7);
        chk("init_busy_cycles", busy_cnt, 32);
        chk("init_busy_end", busy, 0);
        chk("init_paddle_x", paddle_x, 72);

        clr();
        left_n = 1'b0;
        lat = 0;
        for (int k = 0; k < 10 && !plot; k++) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 4);
        cyc(10 - lat);
        left_n = 1'b1;
        cyc(80);
        chk("left_pixels", q.size(), 64);
        scan("left_erase", 0, 72, 0);
        scan("left_draw", 32, 68, 7);
        chk("left_busy_cycles", busy_cnt, 64);
        chk("left_busy_run", max_run, 64);
        chk("left_paddle_x", paddle_x, 68);

        do_reset();
        clr();
        for (int k = 0; k < 18; k++) press_r();
        chk("right18_paddle_x", paddle_x, 144);
        chk("right18_pixels", q.size(), 18 * 64);
        clr();
        press_r();
        press_r();
        chk("clamp_r_paddle_x", paddle_x, 144);
        chk("clamp_r_pixels", q.size(), 0);
        chk("clamp_r_busy", busy_cnt, 0);

        left2_n = 1'b0;
        cyc(3);
        left2_n = 1'b1;
        cyc(75);
        chk("clamp_l_paddle_x", px2, 0);

        do_reset();
        clr();
        left_n = 1'b0;
        cyc(3);
        left_n = 1'b1;
        cyc(5);
        right_n = 1'b0;
        cyc(3);
        right_n = 1'b1;
        cyc(9);
        left_n = 1'b0;
        cyc(3);
        left_n = 1'b1;
        cyc(200);
        chk("pend_pixels", q.size(), 128);
        scan("pend_erase1", 0, 72, 0);
        scan("pend_draw1", 32, 68, 7);
        scan("pend_erase2", 64, 68, 0);
        scan("pend_draw2", 96, 64, 7);
        chk("pend_busy_cycles", busy_cnt, 128);
        chk("pend_busy_run", max_run, 128);
        chk("pend_paddle_x", paddle_x, 64);

        clr();
        left_n = 1'b0;
        right_n = 1'b0;
        cyc(5);
        left_n = 1'b1;
        right_n = 1'b1;
        cyc(20);
        chk("both_pixels", q.size(), 0);
        chk("both_busy", busy_cnt, 0);
        chk("both_paddle_x", paddle_x, 64);

        left_n = 1'b0;
        cyc(14);
        chk("mid_plot", plot, 1);
        chk("mid_x", x, 74);
        resetn = 1'b0;
        left_n = 1'b1;
        cyc(1);
        chk("mid_rst_plot", plot, 0);
        chk("mid_rst_paddle_x", paddle_x, 72);
        clr();
        resetn = 1'b1;
        cyc(40);
        chk("redraw_pixels", q.size(), 32);
        scan("redraw_scan", 0, 72, 7);
        chk("redraw_busy_cycles", busy_cnt, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
Parametrised paddle position controller and rectangle plotter for the brick-breaker display path. It takes two active-low push-button inputs and edge-detects them into single move requests. Each accepted move updates a clamped paddle x-position. An FSM then erases the old paddle rectangle and draws the new one, one pixel per clock, into the vga_adapter plot interface (x, y, colour, plot).

Parameters:
X_BITS, 8, width of x coordinate
Y_BITS, 7, width of y coordinate
COLOUR_BITS, 3, width of colour bus
SCREEN_W, 160, screen width in pixels
PADDLE_W, 16, paddle width in pixels (1..SCREEN_W)
PADDLE_H, 2, paddle height in pixels (>=1)
PADDLE_Y, 112, top row of paddle
X_INIT, 72, paddle x after reset (<= SCREEN_W-PADDLE_W)
STEP, 4, pixels moved per press (>=1)
PADDLE_COLOUR, 3'b111, draw colour
BG_COLOUR, 3'b000, erase colour

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
resetn  in  1  synchronous active-low reset
left_n  in  1  active-low move-left button (asynchronous level)
right_n  in  1  active-low move-right button (asynchronous level)
x  out  X_BITS  pixel x to plotter
y  out  Y_BITS  pixel y to plotter
colour  out  COLOUR_BITS  pixel colour
plot  out  1  pixel write strobe, one pixel per high cycle
busy  out  1  high while ERASE or DRAW is active
paddle_x  out  X_BITS  current paddle left edge

Behaviour:
- One clock, CLOCK_50. Reset is synchronous and active-low on resetn; polarity and synchronicity are fixed.
- Reset (resetn=0 at an edge):
  - x=0, y=0, colour=0, plot=0, busy=0.
  - paddle_x=X_INIT; pending request cleared; synchronisers set to 1.
  - FSM=START.
- Input synchronisers:
  - Each button passes through 2 flops (s1, s2) plus a prev flop.
  - A press is s2=0 with prev=1, i.e. a single-cycle event per falling edge. Holding a button produces exactly one press.
- Request resolution per cycle:
  - Left and right press in the same cycle: both ignored.
  - Otherwise the press becomes a request: L or R.
- States:
  - START: goes to DRAW after one cycle, painting the initial paddle at paddle_x.
  - IDLE: on a request, compute target.
    - Left target: max(paddle_x-STEP, 0). Right target: min(paddle_x+STEP, SCREEN_W-PADDLE_W). Compute in X_BITS+1 bits so there is no wrap-around.
    - If target==paddle_x: no action; stay in IDLE, no plot.
    - Otherwise: old_x<=paddle_x, paddle_x<=target, go to ERASE.
  - ERASE: scan the old rectangle with colour=BG_COLOUR.
    - x=old_x+i, y=PADDLE_Y+j; i is the inner loop 0..PADDLE_W-1, j is the outer loop 0..PADDLE_H-1.
    - plot=1 every cycle, PADDLE_W*PADDLE_H cycles; then go to DRAW.
  - DRAW: same scan over paddle_x with colour=PADDLE_COLOUR; then go to IDLE, or straight to request handling if a request is pending.
- Outputs:
  - x, y, colour and plot are registered.
  - plot is low in IDLE and START.
  - busy=1 exactly while ERASE or DRAW outputs are being presented.
- Latency: the first ERASE pixel is presented (plot=1) on the 4th rising edge after the edge that first samples left_n/right_n low.
- Requests while busy:
  - Held in a one-deep pending register; a later request overwrites an earlier one.
  - On DRAW completion the pending request is evaluated as in IDLE with no gap. If it moves the paddle, busy stays high continuously.
  - Pending is cleared when consumed.
- paddle_x changes only on entry to ERASE; it is stable throughout ERASE/DRAW.
- Reset mid-operation: plot drops on the next cycle; pending is discarded; the paddle is redrawn at X_INIT via START. The stale paddle is not erased; clearing the screen is the caller's job.

Test Plan:
- Reset with resetn=0 for 2 cycles, then release:
  - 32 plot pulses, x 72..87 for y=112, then for y=113, colour=7.
  - busy then 0; paddle_x=72.
- left_n low for 10 cycles:
  - 32 erase pulses over x 72..87 with colour 0, then 32 draw pulses over x 68..83 with colour 7.
  - busy high for exactly 64 cycles; paddle_x=68.
  - Exactly one move despite the held key.
- 18 separate right presses from 72:
  - paddle_x reaches 144 and stays there.
  - Presses at 144 produce no plot and busy stays 0.
  - From paddle_x=2, one left press gives paddle_x=0 (clamped).
- Right press during ERASE, then a left press during the same operation:
  - Only the left is applied after DRAW completes.
  - busy stays high for 128 contiguous cycles.
- Edge cases:
  - left_n and right_n falling on the same edge: no move, no plot.
  - resetn=0 at ERASE pixel 10: plot=0 next cycle, paddle_x=72, then a fresh 32-pixel DRAW.
